rounder_arbiter: RTL and testbench



---
 rtl/rounder_arbiter.sv | 138 +++++++++++++
 tb/tb_rounder_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rounder_arbiter.sv
// Round-robin arbiter sharing one combinational rounder among NUM_LANES accumulator lanes.
// Optional saturation-event counter port sat_cnt is enabled by defining ROUNDER_ARB_SAT_CNT_EN.
module rounder_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    localparam int ID_WIDTH = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          req_valid,
    input  logic [NUM_LANES*IN_WIDTH-1:0] req_data,
    output logic [NUM_LANES-1:0]          req_ready,
    output logic [IN_WIDTH-1:0]           rnd_in,
    input  logic [OUT_WIDTH-1:0]          rnd_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [ID_WIDTH-1:0]           out_id
`ifdef ROUNDER_ARB_SAT_CNT_EN
    ,
    output logic [15:0]                   sat_cnt
`endif
);

    localparam int CW = ID_WIDTH + 1;
    localparam logic [CW-1:0]       NL   = CW'(NUM_LANES);
    localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_LANES - 1);

    // Handshakes: a lane word moves when req_valid[k] & req_ready[k]; a result
    // leaves when out_valid & out_ready. Valid never waits on ready.
    logic                 s1_v_q;
    logic [IN_WIDTH-1:0]  s1_data_q;
    logic [ID_WIDTH-1:0]  s1_id_q;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [ID_WIDTH-1:0]  out_id_q;
    logic [ID_WIDTH-1:0]  ptr_q;
    logic [ID_WIDTH-1:0]  ptr_d;

    logic                 s2_load;
    logic                 s1_load;
    logic                 grant_vld;
    logic                 grant_fire;
    logic [ID_WIDTH-1:0]  grant_id;
    logic [CW-1:0]        cand;
    logic [IN_WIDTH-1:0]  lane_word [NUM_LANES];

    assign s2_load    = s1_v_q & (~out_valid_q | out_ready);
    assign s1_load    = ~s1_v_q | s2_load;
    assign grant_fire = s1_load & grant_vld & ~rst;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_word[k] = req_data[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Search upward from ptr_q, wrapping at NUM_LANES; first valid lane wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= NL) begin
                cand = cand - NL;
            end
            if (!grant_vld && req_valid[cand[ID_WIDTH-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            req_ready[k] = grant_fire && (grant_id == ID_WIDTH'(k));
        end
    end

    assign ptr_d = (grant_id == LAST) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            if (s2_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rnd_out;
                out_id_q    <= s1_id_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (s1_load) begin
                if (grant_vld) begin
                    s1_v_q    <= 1'b1;
                    s1_data_q <= lane_word[grant_id];
                    s1_id_q   <= grant_id;
                    ptr_q     <= ptr_d;
                end else begin
                    s1_v_q <= 1'b0;
                end
            end
        end
    end

    assign rnd_in    = s1_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef ROUNDER_ARB_SAT_CNT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [15:0] sat_cnt_q;

    // Counts rounder results pinned at either rail; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (s2_load && (rnd_out == SAT_MAX || rnd_out == SAT_MIN)
                     && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_rounder_arbiter.sv
// Self-checking bench for rounder_arbiter: vector table, hand sequences, and
// randomized traffic against a transaction-level pipeline model.
module tb_rounder_arbiter;

  localparam int NL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  rnd_in;
  logic [15:0]  rnd_out;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [1:0]   out_id;
`ifdef ROUNDER_ARB_SAT_CNT_EN
  logic [15:0]  sat_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // stub rounder
  assign rnd_out = rnd_in[24:9];

  rounder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rnd_in    (rnd_in),
    .rnd_out   (rnd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef ROUNDER_ARB_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Words in flight, oldest first: {lane id, word}, with acceptance cycle.
  logic [33:0] exp_q[$];
  int          acc_t_q[$];
  int          m_ptr = 0;
  int          now = 0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < NL; i++) begin
      if (v[(p + i) % NL]) return (p + i) % NL;
    end
    return -1;
  endfunction

  function automatic logic [15:0] stub_round(input logic [31:0] w);
    return w[24:9];
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, samples at negedge, returns at next posedge+1.
  task automatic do_cycle(input logic r, input logic [3:0] v, input logic [127:0] d,
                          input logic ro, output logic [3:0] rr_a, output logic ov_a,
                          output logic [15:0] od_a, output logic [1:0] oid_a,
                          output logic [31:0] ri_a);
    logic        exp_ov;
    logic [3:0]  exp_rr;
    logic [33:0] head;
    int          k;
    rst       = r;
    req_valid = v;
    req_data  = d;
    out_ready = ro;
    exp_ov = (exp_q.size() > 0) && (acc_t_q[0] <= now - 2);
    k = -1;
    if (!r && (exp_q.size() < 2 || (exp_ov && ro))) k = rr_pick(v, m_ptr);
    exp_rr = (k >= 0) ? (4'b0001 << k) : 4'b0000;
    @(negedge clk);
    rr_a  = req_ready;
    ov_a  = out_valid;
    od_a  = out_data;
    oid_a = out_id;
    ri_a  = rnd_in;
    chk("model_req_ready", 32'(rr_a), 32'(exp_rr));
    chk("model_out_valid", 32'(ov_a), 32'(exp_ov));
    if (exp_ov) begin
      head = exp_q[0];
      chk("model_out_data", 32'(od_a), 32'(stub_round(head[31:0])));
      chk("model_out_id", 32'(oid_a), 32'(head[33:32]));
    end
    if (r) begin
      exp_q.delete();
      acc_t_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_ov && ro) begin
        void'(exp_q.pop_front());
        void'(acc_t_q.pop_front());
      end
      if (k >= 0) begin
        exp_q.push_back({2'(k), d[k*32 +: 32]});
        acc_t_q.push_back(now);
        m_ptr = (k + 1) % NL;
      end
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        ro;
    logic [3:0]  rr;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  oid;
  } vec_t;

  localparam logic [127:0] TBL_DATA = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_2345};

  vec_t tbl[17];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic ro,
                              input logic [3:0] rr, input logic ov,
                              input logic [15:0] od, input logic [1:0] oid);
    vec_t e;
    e.rst = r; e.v = v; e.ro = ro; e.rr = rr; e.ov = ov; e.od = od; e.oid = oid;
    return e;
  endfunction

  logic [3:0]  rr;
  logic        ov;
  logic [15:0] od;
  logic [1:0]  oid;
  logic [31:0] ri;
  logic [15:0] held;
  int          n_acc;
  int          n_out;

  function automatic logic [127:0] lane1_vec(input int n);
    logic [127:0] d;
    d = '0;
    d[63:32] = 32'h0001_0000 + 32'(n) * 32'h200;
    return d;
  endfunction

  initial begin
    // single word, then all lanes from reset, then round-robin after lane 2
    tbl[0]  = mk(0, 4'b0001, 1, 4'b0001, 0, 16'h0000, 2'd0);
    tbl[1]  = mk(0, 4'b0000, 1, 4'b0000, 0, 16'h0000, 2'd0);
    tbl[2]  = mk(0, 4'b0000, 1, 4'b0000, 1, 16'h0091, 2'd0);
    tbl[3]  = mk(1, 4'b0000, 1, 4'b0000, 0, 16'h0000, 2'd0);
    tbl[4]  = mk(0, 4'b1111, 1, 4'b0001, 0, 16'h0000, 2'd0);
    tbl[5]  = mk(0, 4'b1111, 1, 4'b0010, 0, 16'h0000, 2'd0);
    tbl[6]  = mk(0, 4'b1111, 1, 4'b0100, 1, 16'h0091, 2'd0);
    tbl[7]  = mk(0, 4'b1111, 1, 4'b1000, 1, 16'h0100, 2'd1);
    tbl[8]  = mk(0, 4'b0000, 1, 4'b0000, 1, 16'h0180, 2'd2);
    tbl[9]  = mk(0, 4'b0000, 1, 4'b0000, 1, 16'h0200, 2'd3);
    tbl[10] = mk(0, 4'b0000, 1, 4'b0000, 0, 16'h0000, 2'd0);
    tbl[11] = mk(0, 4'b0100, 1, 4'b0100, 0, 16'h0000, 2'd0);
    tbl[12] = mk(0, 4'b1001, 1, 4'b1000, 0, 16'h0000, 2'd0);
    tbl[13] = mk(0, 4'b1001, 1, 4'b0001, 1, 16'h0180, 2'd2);
    tbl[14] = mk(0, 4'b0000, 1, 4'b0000, 1, 16'h0200, 2'd3);
    tbl[15] = mk(0, 4'b0000, 1, 4'b0000, 1, 16'h0091, 2'd0);
    tbl[16] = mk(0, 4'b0000, 1, 4'b0000, 0, 16'h0000, 2'd0);

    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_id", 32'(out_id), 32'h0);
    chk("reset_rnd_in", rnd_in, 32'h0);

    for (int i = 0; i < 17; i++) begin
      do_cycle(tbl[i].rst, tbl[i].v, TBL_DATA, tbl[i].ro, rr, ov, od, oid, ri);
      chk($sformatf("tbl%0d_req_ready", i), 32'(rr), 32'(tbl[i].rr));
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i), 32'(od), 32'(tbl[i].od));
        chk($sformatf("tbl%0d_out_id", i), 32'(oid), 32'(tbl[i].oid));
      end
    end

    // backpressure on lane 1
    do_cycle(1, 4'b0000, '0, 0, rr, ov, od, oid, ri);
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 2; i++) begin
      do_cycle(0, 4'b0010, lane1_vec(n_acc), 0, rr, ov, od, oid, ri);
      chk("bp_fill_ready", 32'(rr), 32'h2);
      if (rr[1]) n_acc++;
    end
    do_cycle(0, 4'b0010, lane1_vec(n_acc), 0, rr, ov, od, oid, ri);
    chk("bp_stall_ready", 32'(rr), 32'h0);
    chk("bp_stall_valid", 32'(ov), 32'h1);
    held = od;
    for (int i = 0; i < 2; i++) begin
      do_cycle(0, 4'b0010, lane1_vec(n_acc), 0, rr, ov, od, oid, ri);
      chk("bp_stall_ready", 32'(rr), 32'h0);
      chk("bp_hold_data", 32'(od), 32'(held));
    end
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 4'b0010, lane1_vec(n_acc), 1, rr, ov, od, oid, ri);
      chk("bp_resume_rate", 32'(rr), 32'h2);
      if (rr[1]) n_acc++;
      if (ov) n_out++;
    end
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 4'b0000, '0, 1, rr, ov, od, oid, ri);
      if (ov) n_out++;
    end
    chk("bp_accepted", 32'(n_acc), 32'd8);
    chk("bp_delivered", 32'(n_out), 32'd8);

    // reset with both stages full and pointer at lane 2
    do_cycle(1, 4'b0000, '0, 0, rr, ov, od, oid, ri);
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 4'b1111, {$urandom, $urandom, $urandom, $urandom}, 0, rr, ov, od, oid, ri);
    end
    do_cycle(1, 4'b1111, {$urandom, $urandom, $urandom, $urandom}, 0, rr, ov, od, oid, ri);
    chk("rst_mid_ready", 32'(rr), 32'h0);
    do_cycle(0, 4'b1010, {$urandom, $urandom, $urandom, $urandom}, 1, rr, ov, od, oid, ri);
    chk("rst_out_valid", 32'(ov), 32'h0);
    chk("rst_rnd_in", ri, 32'h0);
    chk("rst_first_grant", 32'(rr), 32'h2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 99) == 0, 4'($urandom_range(0, 15)),
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 9) < 7, rr, ov, od, oid, ri);
    end
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 4'b0000, '0, 1, rr, ov, od, oid, ri);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

`ifdef ROUNDER_ARB_SAT_CNT_EN
    do_cycle(1, 4'b0000, '0, 1, rr, ov, od, oid, ri);
    chk("sat_reset", 32'(sat_cnt), 32'h0);
    do_cycle(0, 4'b0001, {96'h0, 32'h00FF_FE00}, 1, rr, ov, od, oid, ri);
    do_cycle(0, 4'b0001, {96'h0, 32'h0100_0000}, 1, rr, ov, od, oid, ri);
    do_cycle(0, 4'b0001, {96'h0, 32'h0001_2345}, 1, rr, ov, od, oid, ri);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 4'b0000, '0, 1, rr, ov, od, oid, ri);
    end
    chk("sat_count", 32'(sat_cnt), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
